// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multichannel PWM block.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;
    localparam logic DIR_UP      = 1'b0;
    localparam logic DIR_DOWN    = 1'b1;

    // Extract channel i's duty from a packed bus; supports buses up to 1024 bits and cw up to 32.
    function automatic logic [31:0] duty_slice(input logic [1023:0] bus,
                                               input int unsigned   i,
                                               input int unsigned   cw);
        logic [1023:0] shifted;
        shifted = bus >> (i * cw);
        return 32'(shifted) & ((32'd1 << cw) - 32'd1);
    endfunction

endpackage

// File: rtl/pwm_multichannel_if.sv
// Control/status bundle between the register block (master) and the PWM core (slave).
interface pwm_multichannel_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = 8
) ();

    logic                en;
    logic                cfg_wr;
    logic                cfg_mode;
    logic [CW-1:0]       cfg_period;
    logic [NCH*CW-1:0]   cfg_duty;
    logic                cfg_pending;
    logic [CW-1:0]       counter;
    logic                period_end;
    logic [NCH-1:0]      pwm_out;

    modport master (
        output en, cfg_wr, cfg_mode, cfg_period, cfg_duty,
        input  cfg_pending, counter, period_end, pwm_out
    );

    modport slave (
        input  en, cfg_wr, cfg_mode, cfg_period, cfg_duty,
        output cfg_pending, counter, period_end, pwm_out
    );

endinterface

// File: rtl/pwm_compare.sv
// One PWM channel: registered unsigned compare of the shared counter against this channel's duty.
module pwm_compare #(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [CW-1:0] counter,
    input  logic [CW-1:0] duty,
    output logic          pwm_out
);

    logic pwm_q, pwm_d;

    always_comb begin
        pwm_d = en && (counter < duty);
    end

    always_ff @(posedge clk) begin
        if (rst) pwm_q <= 1'b0;
        else     pwm_q <= pwm_d;
    end

    assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_multichannel.sv
// N-channel PWM with a shared edge/center-aligned counter and double-buffered configuration.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int unsigned NCH   = 4,
    parameter int unsigned CW    = 8,
    parameter int unsigned P_RST = 99
) (
    input logic               clk,
    input logic               rst,
    pwm_multichannel_if.slave bus
);

    localparam logic [CW-1:0] PERIOD_RST = CW'(P_RST);

    logic [CW-1:0]     counter_q, counter_d;
    logic              dir_q, dir_d;
    logic              period_end_q, period_end_d;
    logic              run_q, run_d;
    logic              mode_q, mode_d;
    logic [CW-1:0]     period_q, period_d;
    logic [NCH*CW-1:0] duty_q, duty_d;
    logic              sh_mode_q, sh_mode_d;
    logic [CW-1:0]     sh_period_q, sh_period_d;
    logic [NCH*CW-1:0] sh_duty_q, sh_duty_d;
    logic              pending_q, pending_d;
    logic              terminal, apply_now;
    logic [NCH-1:0]    pwm_w;

    always_comb begin
        if (period_q == '0)            terminal = 1'b1;
        else if (mode_q == MODE_EDGE)  terminal = (counter_q == period_q);
        else                           terminal = (dir_q == DIR_DOWN) && (counter_q == CW'(1));
        apply_now = !bus.en || terminal;
    end

    // dir flips to DOWN on the cycle the counter reaches P, so P=1 needs no special case.
    always_comb begin
        counter_d = counter_q;
        dir_d     = dir_q;
        if (apply_now) begin
            counter_d = '0;
            dir_d     = DIR_UP;
        end else if (mode_q == MODE_CENTER && dir_q == DIR_DOWN) begin
            counter_d = counter_q - CW'(1);
        end else begin
            counter_d = counter_q + CW'(1);
            if (mode_q == MODE_CENTER && counter_d == period_q) dir_d = DIR_DOWN;
        end
        period_end_d = bus.en && (terminal || !run_q);
        run_d        = bus.en;
    end

    always_comb begin
        mode_d      = mode_q;
        period_d    = period_q;
        duty_d      = duty_q;
        sh_mode_d   = sh_mode_q;
        sh_period_d = sh_period_q;
        sh_duty_d   = sh_duty_q;
        pending_d   = pending_q;
        if (bus.cfg_wr) begin
            if (apply_now) begin
                mode_d    = bus.cfg_mode;
                period_d  = bus.cfg_period;
                duty_d    = bus.cfg_duty;
                pending_d = 1'b0;
            end else begin
                sh_mode_d   = bus.cfg_mode;
                sh_period_d = bus.cfg_period;
                sh_duty_d   = bus.cfg_duty;
                pending_d   = 1'b1;
            end
        end else if (pending_q && apply_now) begin
            mode_d    = sh_mode_q;
            period_d  = sh_period_q;
            duty_d    = sh_duty_q;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter_q    <= '0;
            dir_q        <= DIR_UP;
            period_end_q <= 1'b0;
            run_q        <= 1'b0;
            mode_q       <= MODE_EDGE;
            period_q     <= PERIOD_RST;
            duty_q       <= '0;
            sh_mode_q    <= MODE_EDGE;
            sh_period_q  <= '0;
            sh_duty_q    <= '0;
            pending_q    <= 1'b0;
        end else begin
            counter_q    <= counter_d;
            dir_q        <= dir_d;
            period_end_q <= period_end_d;
            run_q        <= run_d;
            mode_q       <= mode_d;
            period_q     <= period_d;
            duty_q       <= duty_d;
            sh_mode_q    <= sh_mode_d;
            sh_period_q  <= sh_period_d;
            sh_duty_q    <= sh_duty_d;
            pending_q    <= pending_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CW-1:0] duty_i;
        assign duty_i = CW'(duty_slice(1024'(duty_q), i, CW));
        pwm_compare #(.CW(CW)) u_cmp (
            .clk     (clk),
            .rst     (rst),
            .en      (bus.en),
            .counter (counter_q),
            .duty    (duty_i),
            .pwm_out (pwm_w[i])
        );
    end

    assign bus.counter     = counter_q;
    assign bus.period_end  = period_end_q;
    assign bus.cfg_pending = pending_q;
    assign bus.pwm_out     = pwm_w;

endmodule
